// File: rtl/param_sync_ram.sv
// param_sync_ram: single-port synchronous RAM with byte enables, a fixed
// read latency of 1 or 2 cycles and a post-reset zero-fill sequencer.
//
// Handshake: a request is accepted at a rising edge when ready && cs &&
// (we || re) and rst is low. cs=0 has no effect. A read is answered by
// exactly one rvalid pulse RD_LAT cycles after its accept edge, in request
// order, with rdata held between pulses. An accepted access to an address
// >= DEPTH produces an addr_err pulse in the same cycle its rvalid would
// appear, whether it was a read or a write.
module param_sync_ram #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int RD_LAT    = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  ready,
    output logic                  addr_err,
    output logic                  dbg_state
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_e;

    // Without zero-fill the array is usable straight out of reset.
    localparam state_e RST_STATE = (INIT_ZERO != 0) ? ST_INIT : ST_IDLE;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  ptr_q, ptr_d;
    logic               init_wr;

    logic [DATA_W-1:0]  mem [DEPTH];

    logic               in_range;
    logic               accept;
    logic               rd_acc;
    logic               wr_acc;

    logic               p1_valid_q;
    logic               p1_err_q;
    logic [DATA_W-1:0]  p1_data_q;

    // Address decode: when DEPTH covers the full address space every
    // address is legal, so no comparator is built.
    generate
        if (DEPTH >= (2 ** ADDR_W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_part_range
            assign in_range = (addr < ADDR_W'(DEPTH));
        end
    endgenerate

    assign ready     = (state_q == ST_IDLE);
    assign dbg_state = state_q;

    // An access is accepted only outside reset and only once zero-fill is done.
    assign accept = ready && cs && (we || re) && !rst;
    assign rd_acc = accept && re;
    assign wr_acc = accept && we && in_range;

    // State register for the zero-fill sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic: INIT walks ptr over every word once, then parks in IDLE.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        init_wr = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr = 1'b1;
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Storage array: zero-fill during INIT, byte-masked writes afterwards.
    // Contents are deliberately not cleared by rst.
    always_ff @(posedge clk) begin
        if (init_wr && !rst) begin
            mem[ptr_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // First read stage: samples the old word (read-before-write on a
    // same-cycle we+re) and flags out-of-range accesses. Data only moves
    // on an accepted read so it holds between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid_q <= 1'b0;
            p1_err_q   <= 1'b0;
            p1_data_q  <= '0;
        end else begin
            p1_valid_q <= rd_acc;
            p1_err_q   <= accept && !in_range;
            if (rd_acc) begin
                p1_data_q <= in_range ? mem[addr] : '0;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic               p2_valid_q;
            logic               p2_err_q;
            logic [DATA_W-1:0]  p2_data_q;

            // Optional output register stage; data again only moves with a valid response.
            always_ff @(posedge clk) begin
                if (rst) begin
                    p2_valid_q <= 1'b0;
                    p2_err_q   <= 1'b0;
                    p2_data_q  <= '0;
                end else begin
                    p2_valid_q <= p1_valid_q;
                    p2_err_q   <= p1_err_q;
                    if (p1_valid_q) begin
                        p2_data_q <= p1_data_q;
                    end
                end
            end

            assign rdata    = p2_data_q;
            assign rvalid   = p2_valid_q;
            assign addr_err = p2_err_q;
        end else begin : g_lat1
            assign rdata    = p1_data_q;
            assign rvalid   = p1_valid_q;
            assign addr_err = p1_err_q;
        end
    endgenerate

endmodule
